// File: rtl/rt_mem_req_queue_pkg.sv
// Shared types and constants for the RT-core memory request front-end.
package rt_mem_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ADDR_W = 32;

  // One queued core request.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Issue FSM: IDLE drains the FIFO, WAIT_RD holds while one read is outstanding.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } rd_state_e;

  // mem_main only sees word addresses; low two bits are dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rt_mem_req_queue_sync_fifo.sv
// Small synchronous FIFO with a registered occupancy count.
// The head entry is presented combinationally so the consumer can inspect it
// before deciding to pop.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rt_mem_req_queue.sv
// Per-core request front-end for one mem_main RT port. Queues core loads and
// stores, issues them as single-cycle we_RT/re_RT pulses with at most one read
// outstanding, and returns read data as a one-cycle response pulse.
module rt_mem_req_queue
  import rt_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              we_RT,
  output logic              re_RT,
  output logic [31:0]       addr_RT,
  output logic [DATA_W-1:0] data_RT_in,
  input  logic              rd_rdy_RT,
  input  logic [DATA_W-1:0] data_RT_out,
  output logic              err_align,
  output logic              err_timeout,
  output logic              err_spurious
);

  localparam int unsigned      TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  rd_state_e       state;
  logic [TO_W-1:0] to_cnt;
  mem_req_t        push_req;
  mem_req_t        head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;

  // Pack the incoming request for the queue.
  always_comb begin
    push_req       = '0;
    push_req.we    = req_we;
    push_req.addr  = req_addr;
    push_req.wdata = req_wdata;
  end

  // Only IDLE consumes the queue, which keeps stores behind an outstanding load.
  always_comb begin
    fifo_pop = (state == IDLE) && !fifo_empty;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (mem_req_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue FSM, read timeout, response capture and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      to_cnt       <= '0;
      we_RT        <= 1'b0;
      re_RT        <= 1'b0;
      addr_RT      <= '0;
      data_RT_in   <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      err_align    <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      we_RT      <= 1'b0;
      re_RT      <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_rdy_RT) begin
            err_spurious <= 1'b1;
          end
          if (!fifo_empty) begin
            addr_RT <= word_align(head.addr);
            if (head.addr[1:0] != 2'b00) begin
              err_align <= 1'b1;
            end
            if (head.we) begin
              we_RT      <= 1'b1;
              data_RT_in <= head.wdata;
            end else begin
              re_RT  <= 1'b1;
              to_cnt <= '0;
              state  <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          // Data takes priority over a timeout on the same edge.
          if (rd_rdy_RT) begin
            resp_data  <= data_RT_out;
            resp_valid <= 1'b1;
            state      <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            resp_data   <= '0;
            resp_valid  <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
